// File: rtl/voice_allocator.sv
// Voice allocator: maps note-on/off events onto a fixed pool of voices with age-based stealing.
// Define VOICE_ALLOCATOR_STEAL_EN to steal the oldest voice when the pool is full (otherwise the event is dropped).
module voice_allocator #(
    parameter int NOTE_WIDTH  = 7,
    parameter int VOICE_COUNT = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              note_valid,
    output logic                              note_ready,
    input  logic                              note_on,
    input  logic [NOTE_WIDTH-1:0]             note_number,
    input  logic [NOTE_WIDTH-1:0]             note_velocity,
    output logic [VOICE_COUNT-1:0]            voice_active,
    output logic [VOICE_COUNT*NOTE_WIDTH-1:0] voice_note,
    output logic [VOICE_COUNT*NOTE_WIDTH-1:0] voice_velocity,
    output logic [VOICE_COUNT-1:0]            voice_trigger,
    output logic [VOICE_COUNT-1:0]            voice_release,
    output logic                              event_dropped
);
    localparam int AGE_WIDTH = $clog2(VOICE_COUNT);

    typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT} state_t;
    state_t state, state_next;

    logic                  ev_on;
    logic [NOTE_WIDTH-1:0] ev_note, ev_vel;

    logic [VOICE_COUNT-1:0] active_q, active_n;
    logic [NOTE_WIDTH-1:0]  note_q [VOICE_COUNT];
    logic [NOTE_WIDTH-1:0]  note_n [VOICE_COUNT];
    logic [NOTE_WIDTH-1:0]  vel_q  [VOICE_COUNT];
    logic [NOTE_WIDTH-1:0]  vel_n  [VOICE_COUNT];
    logic [AGE_WIDTH-1:0]   age_q  [VOICE_COUNT];
    logic [AGE_WIDTH-1:0]   age_n  [VOICE_COUNT];
    logic [VOICE_COUNT-1:0] trigger_q, trigger_n, release_q, release_n;
    logic                   dropped_q, dropped_n;

    logic                 hit_found, free_found, alloc, was_active;
    logic [AGE_WIDTH-1:0] hit_idx, free_idx, victim;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (note_valid) state_next = LOOKUP;
            LOOKUP:  state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = VOICE_COUNT - 1; i >= 0; i--) begin
            if (active_q[i] && note_q[i] == ev_note) begin
                hit_found = 1'b1;
                hit_idx   = AGE_WIDTH'(i);
            end
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = AGE_WIDTH'(i);
            end
        end
    end

`ifdef VOICE_ALLOCATOR_STEAL_EN
    logic [AGE_WIDTH-1:0] oldest_idx, oldest_age;

    always_comb begin
        oldest_idx = '0;
        oldest_age = age_q[0];
        for (int i = 1; i < VOICE_COUNT; i++) begin
            if (age_q[i] > oldest_age) begin
                oldest_idx = AGE_WIDTH'(i);
                oldest_age = age_q[i];
            end
        end
    end
`endif

    // The table update lands on the LOOKUP->COMMIT edge so COMMIT already shows it.
    always_comb begin
        active_n   = active_q;
        note_n     = note_q;
        vel_n      = vel_q;
        age_n      = age_q;
        trigger_n  = '0;
        release_n  = '0;
        dropped_n  = 1'b0;
        alloc      = 1'b0;
        victim     = '0;
        was_active = 1'b0;
        if (state == LOOKUP) begin
            if (ev_on) begin
                if (hit_found) begin
                    alloc      = 1'b1;
                    victim     = hit_idx;
                    was_active = 1'b1;
                end else if (free_found) begin
                    alloc  = 1'b1;
                    victim = free_idx;
                end else begin
`ifdef VOICE_ALLOCATOR_STEAL_EN
                    alloc      = 1'b1;
                    victim     = oldest_idx;
                    was_active = 1'b1;
`else
                    dropped_n  = 1'b1;
`endif
                end
                if (alloc) begin
                    for (int i = 0; i < VOICE_COUNT; i++) begin
                        if (active_q[i] && AGE_WIDTH'(i) != victim &&
                            (!was_active || age_q[i] < age_q[victim]))
                            age_n[i] = age_q[i] + AGE_WIDTH'(1);
                    end
                    active_n[victim]  = 1'b1;
                    age_n[victim]     = '0;
                    note_n[victim]    = ev_note;
                    vel_n[victim]     = ev_vel;
                    trigger_n[victim] = 1'b1;
                end
            end else if (hit_found) begin
                for (int i = 0; i < VOICE_COUNT; i++) begin
                    if (active_q[i] && age_q[i] > age_q[hit_idx])
                        age_n[i] = age_q[i] - AGE_WIDTH'(1);
                end
                active_n[hit_idx]  = 1'b0;
                age_n[hit_idx]     = '0;
                release_n[hit_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ev_on     <= 1'b0;
            ev_note   <= '0;
            ev_vel    <= '0;
            active_q  <= '0;
            trigger_q <= '0;
            release_q <= '0;
            dropped_q <= 1'b0;
            for (int i = 0; i < VOICE_COUNT; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            state <= state_next;
            // Zero velocity on a note-on is folded into note-off here.
            if (state == IDLE && note_valid) begin
                ev_on   <= note_on && (note_velocity != '0);
                ev_note <= note_number;
                ev_vel  <= note_velocity;
            end
            active_q  <= active_n;
            note_q    <= note_n;
            vel_q     <= vel_n;
            age_q     <= age_n;
            trigger_q <= trigger_n;
            release_q <= release_n;
            dropped_q <= dropped_n;
        end
    end

    always_comb begin
        note_ready     = (state == IDLE) && !reset;
        voice_active   = reset ? '0 : active_q;
        voice_trigger  = reset ? '0 : trigger_q;
        voice_release  = reset ? '0 : release_q;
        event_dropped  = !reset && dropped_q;
        voice_note     = '0;
        voice_velocity = '0;
        for (int i = 0; i < VOICE_COUNT; i++) begin
            if (!reset) begin
                voice_note[i*NOTE_WIDTH +: NOTE_WIDTH]     = note_q[i];
                voice_velocity[i*NOTE_WIDTH +: NOTE_WIDTH] = vel_q[i];
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with a 4-voice pool; expectations follow VOICE_ALLOCATOR_STEAL_EN.
module tb_voice_allocator;
    localparam int NW = 7;
    localparam int VC = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          note_valid = 1'b0;
    logic          note_on = 1'b0;
    logic [NW-1:0] note_number = '0;
    logic [NW-1:0] note_velocity = '0;
    logic          note_ready;
    logic [VC-1:0] voice_active, voice_trigger, voice_release;
    logic [VC*NW-1:0] voice_note, voice_velocity;
    logic          event_dropped;

    int checkCount = 0;
    int failCount  = 0;
    logic [VC*NW-1:0] expNote;

    always #5 clock = ~clock;

    voice_allocator #(.NOTE_WIDTH(NW), .VOICE_COUNT(VC)) dut (
        .clock(clock), .reset(reset), .note_valid(note_valid), .note_ready(note_ready),
        .note_on(note_on), .note_number(note_number), .note_velocity(note_velocity),
        .voice_active(voice_active), .voice_note(voice_note), .voice_velocity(voice_velocity),
        .voice_trigger(voice_trigger), .voice_release(voice_release), .event_dropped(event_dropped)
    );

    function automatic logic [NW-1:0] voiceNote(input int i);
        return voice_note[i*NW +: NW];
    endfunction

    function automatic logic [NW-1:0] voiceVel(input int i);
        return voice_velocity[i*NW +: NW];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Handshakes one event and returns mid-way through its COMMIT cycle.
    task automatic applyStimulus(input logic on, input logic [NW-1:0] num, input logic [NW-1:0] vel);
        int guard = 0;
        while (note_ready !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 20) checkOutput("ready_timeout", {31'd0, note_ready}, 32'd1);
        note_valid    = 1'b1;
        note_on       = on;
        note_number   = num;
        note_velocity = vel;
        @(posedge clock);
        @(negedge clock);
        note_valid = 1'b0;
        checkOutput("ready_lookup", {31'd0, note_ready}, 32'd0);
        @(negedge clock);
        checkOutput("ready_commit", {31'd0, note_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        checkOutput("rst_ready", {31'd0, note_ready}, 32'd0);
        checkOutput("rst_active", {28'd0, voice_active}, 32'd0);
        checkOutput("rst_trigger", {28'd0, voice_trigger}, 32'd0);
        checkOutput("rst_note", {4'd0, voice_note}, 32'd0);
        reset = 1'b0;
        #1 checkOutput("ready_after_rst", {31'd0, note_ready}, 32'd1);

        applyStimulus(1'b1, 7'd60, 7'd100);
        checkOutput("on60_trigger", {28'd0, voice_trigger}, 32'h1);
        checkOutput("on60_active", {28'd0, voice_active}, 32'h1);
        checkOutput("on60_note", {25'd0, voiceNote(0)}, 32'd60);
        checkOutput("on60_vel", {25'd0, voiceVel(0)}, 32'd100);
        checkOutput("on60_drop", {31'd0, event_dropped}, 32'd0);
        @(negedge clock);
        checkOutput("on60_trig_clear", {28'd0, voice_trigger}, 32'h0);
        checkOutput("on60_ready_c3", {31'd0, note_ready}, 32'd1);

        applyStimulus(1'b1, 7'd62, 7'd90);
        checkOutput("on62_trigger", {28'd0, voice_trigger}, 32'h2);
        applyStimulus(1'b1, 7'd64, 7'd80);
        checkOutput("on64_trigger", {28'd0, voice_trigger}, 32'h4);
        checkOutput("on64_active", {28'd0, voice_active}, 32'h7);

        applyStimulus(1'b0, 7'd62, 7'd0);
        checkOutput("off62_release", {28'd0, voice_release}, 32'h2);
        checkOutput("off62_trigger", {28'd0, voice_trigger}, 32'h0);
        checkOutput("off62_active", {28'd0, voice_active}, 32'h5);
        checkOutput("off62_note_kept", {25'd0, voiceNote(1)}, 32'd62);

        applyStimulus(1'b1, 7'd65, 7'd70);
        checkOutput("on65_trigger", {28'd0, voice_trigger}, 32'h2);
        checkOutput("on65_active", {28'd0, voice_active}, 32'h7);
        checkOutput("on65_note", {25'd0, voiceNote(1)}, 32'd65);

        applyStimulus(1'b1, 7'd60, 7'd30);
        checkOutput("retrig_trigger", {28'd0, voice_trigger}, 32'h1);
        checkOutput("retrig_vel", {25'd0, voiceVel(0)}, 32'd30);
        checkOutput("retrig_active", {28'd0, voice_active}, 32'h7);
        checkOutput("retrig_release", {28'd0, voice_release}, 32'h0);

        applyStimulus(1'b1, 7'd62, 7'd50);
        checkOutput("on62b_trigger", {28'd0, voice_trigger}, 32'h8);
        checkOutput("on62b_active", {28'd0, voice_active}, 32'hF);

        // Ages now: v0=1 v1=2 v2=3 v3=0, so voice 2 (note 64) is oldest.
        applyStimulus(1'b1, 7'd67, 7'd40);
`ifdef VOICE_ALLOCATOR_STEAL_EN
        checkOutput("full_trigger", {28'd0, voice_trigger}, 32'h4);
        checkOutput("full_note", {25'd0, voiceNote(2)}, 32'd67);
        checkOutput("full_drop", {31'd0, event_dropped}, 32'd0);
`else
        checkOutput("full_trigger", {28'd0, voice_trigger}, 32'h0);
        checkOutput("full_note", {25'd0, voiceNote(2)}, 32'd64);
        checkOutput("full_drop", {31'd0, event_dropped}, 32'd1);
`endif
        checkOutput("full_release", {28'd0, voice_release}, 32'h0);
        checkOutput("full_active", {28'd0, voice_active}, 32'hF);
        @(negedge clock);
        checkOutput("full_drop_clear", {31'd0, event_dropped}, 32'd0);

`ifdef VOICE_ALLOCATOR_STEAL_EN
        applyStimulus(1'b0, 7'd67, 7'd0);
`else
        applyStimulus(1'b0, 7'd64, 7'd0);
`endif
        checkOutput("free2_release", {28'd0, voice_release}, 32'h4);
        checkOutput("free2_active", {28'd0, voice_active}, 32'hB);

        applyStimulus(1'b1, 7'd72, 7'd60);
        checkOutput("on72_trigger", {28'd0, voice_trigger}, 32'h4);
        checkOutput("on72_active", {28'd0, voice_active}, 32'hF);

        applyStimulus(1'b1, 7'd72, 7'd0);
        checkOutput("vel0_release", {28'd0, voice_release}, 32'h4);
        checkOutput("vel0_trigger", {28'd0, voice_trigger}, 32'h0);
        checkOutput("vel0_active", {28'd0, voice_active}, 32'hB);
        checkOutput("vel0_note_kept", {25'd0, voiceNote(2)}, 32'd72);
        checkOutput("vel0_vel_kept", {25'd0, voiceVel(2)}, 32'd60);

        applyStimulus(1'b0, 7'd99, 7'd0);
        expNote = {7'd62, 7'd72, 7'd65, 7'd60};
        checkOutput("off99_release", {28'd0, voice_release}, 32'h0);
        checkOutput("off99_trigger", {28'd0, voice_trigger}, 32'h0);
        checkOutput("off99_active", {28'd0, voice_active}, 32'hB);
        checkOutput("off99_notes", {4'd0, voice_note}, {4'd0, expNote});

        @(negedge clock);
        checkOutput("midrst_ready_pre", {31'd0, note_ready}, 32'd1);
        note_valid    = 1'b1;
        note_on       = 1'b1;
        note_number   = 7'd70;
        note_velocity = 7'd20;
        @(negedge clock);
        note_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clock);
        checkOutput("midrst_trigger", {28'd0, voice_trigger}, 32'h0);
        checkOutput("midrst_active", {28'd0, voice_active}, 32'h0);
        checkOutput("midrst_ready", {31'd0, note_ready}, 32'd0);
        @(negedge clock);
        checkOutput("midrst_trigger2", {28'd0, voice_trigger}, 32'h0);
        reset = 1'b0;
        #1 checkOutput("midrst_ready_after", {31'd0, note_ready}, 32'd1);

        applyStimulus(1'b1, 7'd50, 7'd10);
        checkOutput("post_rst_trigger", {28'd0, voice_trigger}, 32'h1);
        checkOutput("post_rst_active", {28'd0, voice_active}, 32'h1);
        checkOutput("post_rst_note", {25'd0, voiceNote(0)}, 32'd50);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
